core_seq: RTL

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/npc_pkg.sv | 20 ++
 rtl/seq_perf_cnt.sv | 46 ++++
 rtl/core_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// ---------------------------------------------------------------------------
// npc_pkg -- shared definitions for the multi-cycle core sequencer.
//   state_e   : FSM state encodings (FETCH=0 .. HALT=6), exposed on core_seq.state
//   CNT_W_DEF : default width of the optional performance counters
// ---------------------------------------------------------------------------
package npc_pkg;

   localparam int CNT_W_DEF = 64;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_IWAIT = 3'd1,
      ST_EXEC  = 3'd2,
      ST_MEM   = 3'd3,
      ST_DWAIT = 3'd4,
      ST_WB    = 3'd5,
      ST_HALT  = 3'd6
   } state_e;

endpackage

// File: rtl/seq_perf_cnt.sv
// ---------------------------------------------------------------------------
// seq_perf_cnt -- cycle and retired-instruction counters for core_seq.
// Only instantiated when CORE_SEQ_PERF_EN is defined.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   inc_cyc_i         : count this cycle (core not halted)
//   inc_ret_i         : an instruction retires this cycle (WB)
//   cycle_cnt_o       : cycle counter, wraps modulo 2^CNT_W
//   instret_cnt_o     : retired-instruction counter, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module seq_perf_cnt #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_cyc_i,
   input  logic             inc_ret_i,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instret_cnt_o
);

   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ret_q, ret_d;

   // Plain unsigned add; overflow drops the carry, giving the modulo wrap.
   always_comb begin
      cyc_d = cyc_q;
      ret_d = ret_q;
      if (inc_cyc_i) cyc_d = cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (inc_ret_i) ret_d = ret_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ret_q <= ret_d;
      end
   end

   assign cycle_cnt_o   = cyc_q;
   assign instret_cnt_o = ret_q;

endmodule

// File: rtl/core_seq.sv
// ---------------------------------------------------------------------------
// core_seq -- multi-cycle control sequencer:
//   FETCH -> IWAIT -> EXEC -> [MEM -> DWAIT] -> WB -> FETCH, with an absorbing HALT.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   imem_req_valid/ready             : instruction-fetch request handshake
//   imem_resp_valid                  : instruction word present, IR is written
//   dec_RegWr/MemRd/MemWr/halt       : decoded controls of the instruction in IR
//   dmem_req_valid/wr/ready          : data request handshake (wr=1 store)
//   dmem_resp_valid                  : load data / store acknowledge
//   ir_we, rf_we, pc_we              : single-cycle write strobes
//   state, halted                    : FSM state encoding, halt indication
//   cycle_cnt, instret_cnt           : performance counters (CORE_SEQ_PERF_EN only)
// Configuration macro: CORE_SEQ_PERF_EN adds the performance counters.
// ---------------------------------------------------------------------------
module core_seq
   import npc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   input  logic             imem_resp_valid,
   input  logic             dec_RegWr,
   input  logic             dec_MemRd,
   input  logic             dec_MemWr,
   input  logic             dec_halt,
   output logic             dmem_req_valid,
   output logic             dmem_req_wr,
   input  logic             dmem_req_ready,
   input  logic             dmem_resp_valid,
   output logic             ir_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic [2:0]       state,
   output logic             halted
`ifdef CORE_SEQ_PERF_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
`endif
);

   state_e state_q, state_d;
   logic   ifetch_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   // Every output is a function of state_q plus the handshake inputs of the
   // current state, so responses arriving in other states fall through unused.
   always_comb begin
      state_d        = state_q;
      ifetch_c       = 1'b0;
      dmem_req_valid = 1'b0;
      dmem_req_wr    = 1'b0;
      ir_we          = 1'b0;
      rf_we          = 1'b0;
      pc_we          = 1'b0;
      halted         = 1'b0;
      case (state_q)
         ST_FETCH: begin
            ifetch_c = 1'b1;
            if (imem_req_ready) state_d = ST_IWAIT;
         end
         ST_IWAIT: begin
            if (imem_resp_valid) begin
               ir_we   = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (dec_halt)                    state_d = ST_HALT;
            else if (dec_MemRd || dec_MemWr) state_d = ST_MEM;
            else                             state_d = ST_WB;
         end
         ST_MEM: begin
            // Rd+Wr together resolves to a store because wr follows MemWr.
            dmem_req_valid = 1'b1;
            dmem_req_wr    = dec_MemWr;
            if (dmem_req_ready) state_d = ST_DWAIT;
         end
         ST_DWAIT: begin
            if (dmem_resp_valid) state_d = ST_WB;
         end
         ST_WB: begin
            pc_we   = 1'b1;
            rf_we   = dec_RegWr & ~dec_MemWr;
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // state_q is already FETCH while rst is high; only the fetch request
   // (the FETCH-state output) needs masking to keep outputs quiet in reset.
   assign imem_req_valid = ifetch_c & ~rst;
   assign state          = state_q;

`ifdef CORE_SEQ_PERF_EN
   seq_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .clk           (clk),
      .rst           (rst),
      .inc_cyc_i     (state_q != ST_HALT),
      .inc_ret_i     (state_q == ST_WB),
      .cycle_cnt_o   (cycle_cnt),
      .instret_cnt_o (instret_cnt)
   );
`endif

endmodule
